// File: rtl/dtw_ref_mem_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dtw_ref_mem_ctrl                                                |
// | Purpose  : Load/replay sequencer for the single-port DTW reference BRAM.  |
// |            Optional macro DTW_REF_CTRL_LOOP_EN replays continuously.       |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module dtw_ref_mem_ctrl #(
   parameter int width  = 16,
   parameter int ptrWid = 18
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_start,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [width-1:0]  ld_data,
   input  logic              ld_last,
   input  logic              str_start,
   input  logic              str_stop,
   output logic              str_valid,
   input  logic              str_ready,
   output logic [width-1:0]  str_data,
   output logic              str_last,
   output logic              busy,
   output logic              done,
   output logic              ovf,
   output logic [ptrWid:0]   ref_len,
   output logic              mem_wen,
   output logic [ptrWid-1:0] mem_addr,
   output logic [width-1:0]  mem_din,
   input  logic [width-1:0]  mem_dout
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LOAD   = 2'd1,
      S_STREAM = 2'd2,
      S_DRAIN  = 2'd3
   } state_t;

   state_t            r_state;
   logic [ptrWid:0]   r_waddr;
   logic [ptrWid-1:0] r_raddr;
   logic [ptrWid-1:0] r_addr_last;
   logic [ptrWid:0]   r_ref_len;
   logic              r_done;
   logic              r_ovf;
   logic              r_inf;
   logic              r_inf_last;
   logic [1:0]        r_occ;
   logic [width-1:0]  r_fd0, r_fd1;
   logic              r_fl0, r_fl1;

   logic w_accept;
   logic w_wr;
   logic w_pop;
   logic w_issue;
   logic w_last_rd;
   logic w_drained;

   assign w_accept  = (r_state == S_LOAD) && ld_valid;
   // waddr MSB set means depth entries are already written
   assign w_wr      = w_accept && !r_waddr[ptrWid];
   assign w_pop     = (r_occ != 2'd0) && str_ready;
   assign w_last_rd = (({1'b0, r_raddr} + (ptrWid+1)'(1)) == r_ref_len);
   // a beat leaving this cycle frees a slot, keeping 1 beat/cycle sustained
   assign w_issue   = (r_state == S_STREAM) && !str_stop &&
                      (((r_occ + {1'b0, r_inf}) != 2'd2) || w_pop);
   assign w_drained = !r_inf && ((r_occ == 2'd0) || ((r_occ == 2'd1) && w_pop));

   always_comb begin
      mem_addr = r_addr_last;
      if (w_wr)
         mem_addr = r_waddr[ptrWid-1:0];
      else if (w_issue)
         mem_addr = r_raddr;
   end

   assign mem_wen   = w_wr;
   assign mem_din   = w_wr ? ld_data : '0;
   assign ld_ready  = (r_state == S_LOAD);
   assign busy      = (r_state != S_IDLE);
   assign done      = r_done;
   assign ovf       = r_ovf;
   assign ref_len   = r_ref_len;
   assign str_valid = (r_occ != 2'd0);
   assign str_data  = r_fd0;
   assign str_last  = r_fl0 && (r_occ != 2'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_waddr     <= '0;
         r_raddr     <= '0;
         r_addr_last <= '0;
         r_ref_len   <= '0;
         r_done      <= 1'b0;
         r_ovf       <= 1'b0;
         r_inf       <= 1'b0;
         r_inf_last  <= 1'b0;
         r_occ       <= 2'd0;
         r_fd0       <= '0;
         r_fd1       <= '0;
         r_fl0       <= 1'b0;
         r_fl1       <= 1'b0;
      end else begin
         r_done     <= 1'b0;
         r_inf      <= w_issue;
         r_inf_last <= w_last_rd;
         if (w_wr || w_issue)
            r_addr_last <= mem_addr;

         // two-entry output FIFO, head always in slot 0
         unique case ({r_inf, w_pop})
            2'b10: begin
               if (r_occ == 2'd0) begin
                  r_fd0 <= mem_dout;
                  r_fl0 <= r_inf_last;
               end else begin
                  r_fd1 <= mem_dout;
                  r_fl1 <= r_inf_last;
               end
               r_occ <= r_occ + 2'd1;
            end
            2'b01: begin
               r_fd0 <= r_fd1;
               r_fl0 <= r_fl1;
               r_occ <= r_occ - 2'd1;
            end
            2'b11: begin
               if (r_occ == 2'd1) begin
                  r_fd0 <= mem_dout;
                  r_fl0 <= r_inf_last;
               end else begin
                  r_fd0 <= r_fd1;
                  r_fl0 <= r_fl1;
                  r_fd1 <= mem_dout;
                  r_fl1 <= r_inf_last;
               end
            end
            default: ;
         endcase

         unique case (r_state)
            S_IDLE: begin
               if (load_start) begin
                  r_state <= S_LOAD;
                  r_waddr <= '0;
                  r_ovf   <= 1'b0;
               end else if (str_start) begin
                  if (r_ref_len == '0) begin
                     r_done <= 1'b1;
                  end else begin
                     r_state <= S_STREAM;
                     r_raddr <= '0;
                  end
               end
            end
            S_LOAD: begin
               if (w_accept) begin
                  if (w_wr)
                     r_waddr <= r_waddr + (ptrWid+1)'(1);
                  else
                     r_ovf <= 1'b1;
                  if (ld_last) begin
                     r_ref_len <= w_wr ? (r_waddr + (ptrWid+1)'(1)) : r_waddr;
                     r_done    <= 1'b1;
                     r_state   <= S_IDLE;
                  end
               end
            end
            S_STREAM: begin
               if (str_stop) begin
                  r_occ   <= 2'd0;
                  r_inf   <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_IDLE;
               end else if (w_issue) begin
                  if (w_last_rd) begin
`ifdef DTW_REF_CTRL_LOOP_EN
                     r_raddr <= '0;
`else
                     r_state <= S_DRAIN;
`endif
                  end else begin
                     r_raddr <= r_raddr + ptrWid'(1);
                  end
               end
            end
            S_DRAIN: begin
               if (str_stop) begin
                  r_occ   <= 2'd0;
                  r_inf   <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_IDLE;
               end else if (w_drained) begin
                  r_done  <= 1'b1;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dtw_ref_mem_ctrl.sv
`default_nettype none
// Bench for dtw_ref_mem_ctrl with a 3-bit address (depth 8) and a behavioural
// write-first BRAM; stream beats are scored against a queue of expected samples.
module tb_dtw_ref_mem_ctrl;
   localparam int c_w   = 16;
   localparam int c_ptr = 3;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             load_start = 1'b0, ld_valid = 1'b0, ld_last = 1'b0;
   logic [c_w-1:0]   ld_data = '0;
   logic             str_start = 1'b0, str_stop = 1'b0, str_ready = 1'b0;
   logic             ld_ready, str_valid, str_last, busy, done, ovf, mem_wen;
   logic [c_w-1:0]   str_data, mem_din;
   logic [c_w-1:0]   mem_dout = '0;
   logic [c_ptr:0]   ref_len;
   logic [c_ptr-1:0] mem_addr;

   dtw_ref_mem_ctrl #(.width(c_w), .ptrWid(c_ptr)) dut (
      .clk(clk), .rst_n(rst_n),
      .load_start(load_start), .ld_valid(ld_valid), .ld_ready(ld_ready),
      .ld_data(ld_data), .ld_last(ld_last),
      .str_start(str_start), .str_stop(str_stop),
      .str_valid(str_valid), .str_ready(str_ready),
      .str_data(str_data), .str_last(str_last),
      .busy(busy), .done(done), .ovf(ovf), .ref_len(ref_len),
      .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
   );

   always #5 clk = ~clk;

   logic [c_w-1:0] bram [8];
   always @(posedge clk) begin
      if (mem_wen) begin
         bram[mem_addr] <= mem_din;
         mem_dout       <= mem_din;
      end else begin
         mem_dout <= bram[mem_addr];
      end
   end

   int n_total = 0;
   int n_pass  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   typedef struct { logic [c_w-1:0] data; logic last; } beat_t;
   beat_t          exp_q[$];
   logic [c_w-1:0] ref_mem [8];
   int             cyc = 0;
   int             n_beats = 0;
   int             last_cyc = 0;
   int             n_done = 0;
   logic           prev_stall = 1'b0;
   logic [c_w-1:0] prev_data = '0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      beat_t e;
      if (rst_n && str_valid && prev_stall)
         chk("stall_hold", str_data, prev_data);
      if (rst_n && str_valid && str_ready) begin
         if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL extra_beat: got %0h, expected no beat", str_data);
         end else begin
            e = exp_q.pop_front();
            chk("str_data", str_data, e.data);
            chk("str_last", str_last, e.last);
         end
         n_beats++;
         last_cyc = cyc;
      end
      if (done) n_done++;
      prev_stall = rst_n && str_valid && !str_ready;
      prev_data  = str_data;
   end

   typedef struct {
      logic           start;
      logic [c_w-1:0] data;
      logic           last;
      logic           exp_wen;
      logic [2:0]     exp_addr;
      logic [3:0]     exp_len;
      logic           exp_ovf;
   } ld_vec_t;
   ld_vec_t vt [18];

   task automatic run_loads(input int lo, input int hi);
      for (int i = lo; i < hi; i++) begin
         if (vt[i].start) begin
            load_start = 1'b1;
            @(posedge clk); #1;
            load_start = 1'b0;
         end
         ld_valid = 1'b1;
         ld_data  = vt[i].data;
         ld_last  = vt[i].last;
         str_stop = (i == 12);
         @(negedge clk);
         chk("ld_ready", ld_ready, 1'b1);
         chk("mem_wen",  mem_wen, vt[i].exp_wen);
         chk("mem_addr", mem_addr, vt[i].exp_addr);
         chk("mem_din",  mem_din, vt[i].exp_wen ? vt[i].data : 16'h0);
         if (vt[i].exp_wen) ref_mem[vt[i].exp_addr] = vt[i].data;
         @(posedge clk); #1;
         ld_valid = 1'b0;
         ld_last  = 1'b0;
         str_stop = 1'b0;
         if (vt[i].last) begin
            @(negedge clk);
            chk("ld_done",    done, 1'b1);
            chk("ld_busy",    busy, 1'b0);
            chk("ld_ref_len", ref_len, vt[i].exp_len);
            chk("ld_ovf",     ovf, vt[i].exp_ovf);
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic push_exp(input int len);
      for (int i = 0; i < len; i++) exp_q.push_back('{ref_mem[i], (i == len - 1)});
   endtask

   task automatic wait_done(input string name, input int bound);
      for (int c = 0; c < bound; c++) begin
         @(negedge clk);
         if (done) break;
      end
      chk(name, done, 1'b1);
   endtask

   task automatic pulse_str_start();
      str_start = 1'b1;
      @(posedge clk); #1;
      str_start = 1'b0;
   endtask

   initial begin
      int base;
      int first;
      for (int i = 0; i < 8; i++)
         vt[i] = '{(i == 0), 16'(i + 1), (i == 7), 1'b1, 3'(i), 4'd8, 1'b0};
      for (int j = 0; j < 10; j++)
         vt[8 + j] = '{(j == 0), 16'(16'h0011 + j), (j == 9), (j < 8),
                       (j < 8) ? 3'(j) : 3'd7, 4'd8, 1'b1};

      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", busy, 1'b0);
      chk("rst_ld_ready", ld_ready, 1'b0);
      chk("rst_str_valid", str_valid, 1'b0);
      chk("rst_outputs", {done, ovf, mem_wen, ref_len, mem_addr, mem_din}, 32'h0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // ref_len == 0 after reset: a start only pulses done
      base = n_beats;
      pulse_str_start();
      @(negedge clk);
      chk("empty_done", done, 1'b1);
      chk("empty_busy", busy, 1'b0);
      @(negedge clk);
      chk("empty_done_1cyc", done, 1'b0);
      chk("empty_no_beats", n_beats - base, 0);
      @(posedge clk); #1;

      run_loads(0, 8);

`ifndef DTW_REF_CTRL_LOOP_EN
      // full-rate replay
      push_exp(8);
      str_ready = 1'b1;
      base = n_beats;
      pulse_str_start();
      @(negedge clk); chk("lat_c1", str_valid, 1'b0);
      @(negedge clk); chk("lat_c2", str_valid, 1'b0);
      @(negedge clk); chk("lat_first", str_valid, 1'b1);
      first = cyc;
      wait_done("str_done", 30);
      chk("str_busy_end", busy, 1'b0);
      chk("str_beats", n_beats - base, 8);
      chk("str_back2back", last_cyc - first, 7);
      chk("str_q_empty", exp_q.size(), 0);
      @(posedge clk); #1;

      // back-pressure: alternating ready plus a 5-cycle hold
      push_exp(8);
      base = n_beats;
      pulse_str_start();
      for (int c = 0; c < 80; c++) begin
         str_ready = (c >= 5 && c < 10) ? 1'b0 : ((c % 2) == 0);
         @(negedge clk);
         if (done) break;
         @(posedge clk); #1;
      end
      chk("tog_done", done, 1'b1);
      chk("tog_beats", n_beats - base, 8);
      chk("tog_q_empty", exp_q.size(), 0);
      @(posedge clk); #1;

      // abort after the third beat
      str_ready = 1'b1;
      push_exp(8);
      base = n_beats;
      pulse_str_start();
      for (int c = 0; c < 30 && n_beats < base + 3; c++) @(posedge clk);
      #1;
      str_stop  = 1'b1;
      str_ready = 1'b0;
      @(posedge clk); #1;
      str_stop = 1'b0;
      @(negedge clk);
      chk("stop_valid", str_valid, 1'b0);
      chk("stop_done", done, 1'b1);
      chk("stop_busy", busy, 1'b0);
      chk("stop_beats", n_beats - base, 3);
      chk("stop_q_left", exp_q.size(), 5);
      exp_q.delete();
      @(posedge clk); #1;

      // overrun load (str_stop during LOAD is ignored), then replay it
      run_loads(8, 18);
      push_exp(8);
      base = n_beats;
      pulse_str_start();
      for (int c = 0; c < 60; c++) begin
         str_ready = ((c % 3) != 1);
         @(negedge clk);
         if (done) break;
         @(posedge clk); #1;
      end
      chk("ovf_str_done", done, 1'b1);
      chk("ovf_str_beats", n_beats - base, 8);
      chk("ovf_str_q_empty", exp_q.size(), 0);
      @(posedge clk); #1;
`else
      // continuous replay over a 3-sample reference
      load_start = 1'b1;
      @(posedge clk); #1;
      load_start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         ld_valid = 1'b1;
         ld_data  = 16'(i + 1);
         ld_last  = (i == 2);
         ref_mem[i] = 16'(i + 1);
         @(posedge clk); #1;
      end
      ld_valid = 1'b0;
      ld_last  = 1'b0;
      @(negedge clk);
      chk("loop_ref_len", ref_len, 4'd3);
      @(posedge clk); #1;
      for (int k = 0; k < 9; k++) exp_q.push_back('{ref_mem[k % 3], ((k % 3) == 2)});
      str_ready = 1'b1;
      base = n_beats;
      first = n_done;
      pulse_str_start();
      for (int c = 0; c < 40 && n_beats < base + 1; c++) @(posedge clk);
      base = last_cyc;
      for (int c = 0; c < 40 && exp_q.size() > 0; c++) @(posedge clk);
      #1;
      str_stop  = 1'b1;
      str_ready = 1'b0;
      chk("loop_no_early_done", n_done - first, 0);
      chk("loop_no_gaps", last_cyc - base, 8);
      @(posedge clk); #1;
      str_stop = 1'b0;
      @(negedge clk);
      chk("loop_stop_valid", str_valid, 1'b0);
      chk("loop_stop_done", done, 1'b1);
      exp_q.delete();
      @(posedge clk); #1;
`endif

      // asynchronous reset in the middle of a load
      load_start = 1'b1;
      @(posedge clk); #1;
      load_start = 1'b0;
      ld_valid = 1'b1;
      ld_data  = 16'h00AA;
      @(negedge clk);
      chk("mid_wen", mem_wen, 1'b1);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_ld_ready", ld_ready, 1'b0);
      chk("mid_rst_wen", mem_wen, 1'b0);
      chk("mid_rst_outputs", {done, ovf, str_valid, ref_len, mem_addr, mem_din}, 32'h0);
      ld_valid = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_ld_ready", ld_ready, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
